// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage and the control unit it feeds.
package fetch_pkg;

  localparam int DEF_BUS_WIDTH = 16;
  localparam int DEF_PC_WIDTH  = 8;
  localparam int DEF_TIMEOUT   = 15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Opcode field (ir[15:12]) and ALU controls decoded by the control unit.
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4
  } alu_ctrl_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read bus between the fetch unit (master) and the memory (slave).
interface fetch_if #(
  parameter int BUS_WIDTH = 16,
  parameter int PC_WIDTH  = 8
);
  logic                 imem_req;
  logic [PC_WIDTH-1:0]  imem_addr;
  logic [BUS_WIDTH-1:0] imem_rdata;
  logic                 imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/pc_reg.sv
// Program counter: jump takes priority over increment; increment wraps modulo 2^PC_WIDTH.
module pc_reg #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pc_inc,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_addr,
  output logic [PC_WIDTH-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (jump) begin
      pc <= jump_addr;
    end else if (pc_inc) begin
      pc <= pc + PC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns pc, runs the IDLE/REQ/WAIT memory handshake and latches ir.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int PC_WIDTH  = DEF_PC_WIDTH,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_inc,
  input  logic                 jump,
  input  logic [PC_WIDTH-1:0]  jump_addr,
  input  logic                 imem_read,
  fetch_if.master              mem,
  output logic [BUS_WIDTH-1:0] ir,
  output logic                 ir_valid,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 busy,
  output logic                 fetch_err
);

  // The abort fires on the WAIT cycle whose increment would reach TIMEOUT,
  // so exactly TIMEOUT WAIT cycles elapse before returning to IDLE.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] cnt;

  pc_reg #(.PC_WIDTH(PC_WIDTH)) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .pc_inc    (pc_inc),
    .jump      (jump),
    .jump_addr (jump_addr),
    .pc        (pc)
  );

  assign busy = (state == ST_REQ) || (state == ST_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      mem.imem_req  <= 1'b0;
      mem.imem_addr <= '0;
      ir            <= '0;
      ir_valid      <= 1'b0;
      fetch_err     <= 1'b0;
    end else begin
      mem.imem_req <= 1'b0;
      ir_valid     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (imem_read) begin
            mem.imem_addr <= pc;
            mem.imem_req  <= 1'b1;
            state         <= ST_REQ;
          end
        end
        ST_REQ: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem.imem_valid) begin
            ir       <= mem.imem_rdata;
            ir_valid <= 1'b1;
            state    <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            fetch_err <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A request while a fetch is in flight is dropped but flagged.
      if (imem_read && busy) begin
        fetch_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a one-cycle-latency memory model and queued ir expectations.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_inc;
  logic        jump;
  logic [7:0]  jump_addr;
  logic        imem_read;
  logic [15:0] ir;
  logic        ir_valid;
  logic [7:0]  pc;
  logic        busy;
  logic        fetch_err;

  fetch_if #(.BUS_WIDTH(16), .PC_WIDTH(8)) bus ();

  fetch_unit #(.BUS_WIDTH(16), .PC_WIDTH(8), .TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_inc    (pc_inc),
    .jump      (jump),
    .jump_addr (jump_addr),
    .imem_read (imem_read),
    .mem       (bus),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .pc        (pc),
    .busy      (busy),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int req_cnt = 0;
  int vld_cnt = 0;

  logic [15:0] exp_q[$];
  logic        mem_respond = 1'b0;
  logic [15:0] mem_word    = '0;
  logic        pending     = 1'b0;
  logic        force_valid = 1'b0;
  logic [15:0] force_word  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory model: answers one cycle after seeing imem_req.
  initial begin
    bus.imem_valid = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.imem_valid = 1'b0;
      if (pending) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = mem_word;
      end else if (force_valid) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = force_word;
        force_valid    = 1'b0;
      end
      pending = bus.imem_req && mem_respond;
    end
  end

  // Monitor: every ir_valid pulse must match the oldest queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.imem_req) req_cnt++;
      if (ir_valid) begin
        vld_cnt++;
        if (exp_q.size() == 0) begin
          chk("ir_unexpected_valid", 32'(ir), 32'hFFFF_FFFF);
        end else begin
          chk("ir_scoreboard", 32'(ir), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  int req0;
  int vld0;

  initial begin
    reset = 1'b1; pc_inc = 1'b0; jump = 1'b0; jump_addr = '0; imem_read = 1'b0;
    step(2);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ir", 32'(ir), 32'h0);
    chk("rst_ir_valid", 32'(ir_valid), 32'h0);
    chk("rst_req", 32'(bus.imem_req), 32'h0);
    chk("rst_addr", 32'(bus.imem_addr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);
    reset = 1'b0;

    // Basic fetch: imem_read at N -> req at N+1 -> ir/ir_valid at N+3.
    mem_respond = 1'b1; mem_word = 16'hA123;
    imem_read = 1'b1; exp_q.push_back(16'hA123);
    step(1);
    imem_read = 1'b0;
    chk("f1_req", 32'(bus.imem_req), 32'h1);
    chk("f1_addr", 32'(bus.imem_addr), 32'h0);
    chk("f1_busy_req", 32'(busy), 32'h1);
    step(1);
    chk("f1_req_drop", 32'(bus.imem_req), 32'h0);
    chk("f1_busy_wait", 32'(busy), 32'h1);
    chk("f1_no_valid_yet", 32'(ir_valid), 32'h0);
    step(1);
    chk("f1_ir_valid", 32'(ir_valid), 32'h1);
    chk("f1_ir", 32'(ir), 32'hA123);
    chk("f1_busy_idle", 32'(busy), 32'h0);
    chk("f1_pc", 32'(pc), 32'h0);
    step(1);
    chk("f1_valid_pulse", 32'(ir_valid), 32'h0);
    chk("f1_ir_hold", 32'(ir), 32'hA123);

    // Fetch address is the pc before a same-cycle increment.
    jump = 1'b1; jump_addr = 8'h05;
    step(1);
    jump = 1'b0;
    chk("jmp5_pc", 32'(pc), 32'h05);
    mem_word = 16'h5A5A;
    imem_read = 1'b1; pc_inc = 1'b1; exp_q.push_back(16'h5A5A);
    step(1);
    imem_read = 1'b0; pc_inc = 1'b0;
    chk("inc_pc", 32'(pc), 32'h06);
    chk("inc_addr", 32'(bus.imem_addr), 32'h05);
    step(3);

    // Wrap at the top of the address space.
    jump = 1'b1; jump_addr = 8'hFF;
    step(1);
    jump = 1'b0; pc_inc = 1'b1;
    step(1);
    pc_inc = 1'b0;
    chk("wrap_pc", 32'(pc), 32'h00);

    // Jump wins over increment, then fetch from the jump target.
    jump = 1'b1; jump_addr = 8'h40; pc_inc = 1'b1;
    step(1);
    jump = 1'b0; pc_inc = 1'b0;
    chk("jmp_prio_pc", 32'(pc), 32'h40);
    mem_word = 16'h1234;
    imem_read = 1'b1; exp_q.push_back(16'h1234);
    step(1);
    imem_read = 1'b0;
    chk("jmp_addr", 32'(bus.imem_addr), 32'h40);
    step(3);

    // Timeout: memory never answers.
    mem_respond = 1'b0;
    vld0 = vld_cnt;
    chk("to_err_before", 32'(fetch_err), 32'h0);
    imem_read = 1'b1;
    step(1);
    imem_read = 1'b0;
    step(15);
    chk("to_busy_last_wait", 32'(busy), 32'h1);
    chk("to_err_not_yet", 32'(fetch_err), 32'h0);
    step(1);
    chk("to_idle", 32'(busy), 32'h0);
    chk("to_err", 32'(fetch_err), 32'h1);
    chk("to_ir_unchanged", 32'(ir), 32'h1234);
    chk("to_no_valid", 32'(vld_cnt - vld0), 32'h0);

    // Overrun: a second imem_read during WAIT is dropped and flagged.
    do_reset();
    chk("ov_err_cleared", 32'(fetch_err), 32'h0);
    mem_respond = 1'b1; mem_word = 16'hC0DE;
    req0 = req_cnt;
    imem_read = 1'b1; exp_q.push_back(16'hC0DE);
    step(1);
    imem_read = 1'b0;
    step(1);
    imem_read = 1'b1;
    step(1);
    imem_read = 1'b0;
    chk("ov_ir", 32'(ir), 32'hC0DE);
    chk("ov_err", 32'(fetch_err), 32'h1);
    step(2);
    chk("ov_single_req", 32'(req_cnt - req0), 32'h1);

    // Reset during WAIT; a late imem_valid must be ignored.
    do_reset();
    mem_respond = 1'b0;
    pc_inc = 1'b1;
    step(1);
    pc_inc = 1'b0;
    vld0 = vld_cnt;
    imem_read = 1'b1;
    step(1);
    imem_read = 1'b0;
    step(1);
    reset = 1'b1;
    force_word = 16'hBEEF; force_valid = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    chk("rw_ir", 32'(ir), 32'h0);
    chk("rw_ir_valid", 32'(ir_valid), 32'h0);
    chk("rw_pc", 32'(pc), 32'h0);
    chk("rw_err", 32'(fetch_err), 32'h0);
    chk("rw_busy", 32'(busy), 32'h0);
    step(2);
    chk("rw_no_valid", 32'(vld_cnt - vld0), 32'h0);
    chk("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
